freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the period and high-time counters.
REQ-002 SHALL have parameter TIMEOUT, default 1048576: idle-cycle limit, used only when FREQ_METER_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port sig_in, input, 1: asynchronous square wave to measure, for example a divided clock.
REQ-006 SHALL have port meas_en, input, 1: enables measurement while high.
REQ-007 SHALL have port result_ready, input, 1: consumer accepts the result.
REQ-008 SHALL have port result_valid, output, 1: a result is held.
REQ-009 SHALL have port period, output, CNT_W: clk cycles from one sig_in rising edge to the next.
REQ-010 SHALL have port high_time, output, CNT_W: clk cycles from a rising edge to the following falling edge.
REQ-011 SHALL have port overflow, output, 1: a counter saturated during the measurement.
REQ-012 SHALL have port timeout, output, 1: no edge arrived within TIMEOUT cycles; present only when FREQ_METER_TIMEOUT_EN is defined.

Function
REQ-013 SHALL pass sig_in through a 2-flop synchronizer, then an edge-detect register; rise/fall pulses appear 3 clk cycles after the sig_in transition.
REQ-014 SHALL implement the FSM IDLE -> ARM -> MEASURE -> HOLD.
REQ-015 IDLE SHALL go to ARM when meas_en=1.
REQ-016 ARM SHALL wait for a rise pulse, then clear both counters to 1 and go to MEASURE.
REQ-017 In MEASURE, the period counter SHALL increment every cycle.
REQ-018 In MEASURE, the high_time counter SHALL increment every cycle until the first fall pulse, then freeze.
REQ-019 In MEASURE, the next rise pulse SHALL latch period, high_time and overflow, and the FSM SHALL go to HOLD.
REQ-020 Measured values SHALL be exact: a sig_in period of P clk cycles with a high phase of H cycles reports period=P, high_time=H.
REQ-021 Both counters SHALL saturate at all-ones and set a sticky overflow bit, cleared on entry to MEASURE.
REQ-022 In HOLD, result_valid=1 and period, high_time and overflow SHALL stay stable.
REQ-023 In HOLD, a rise pulse SHALL be ignored.
REQ-024 HOLD SHALL exit on result_ready=1: to ARM if meas_en=1, otherwise to IDLE; result_valid drops the following cycle.
REQ-025 meas_en=0 in ARM or MEASURE SHALL return the FSM to IDLE next cycle, discarding the partial count with no valid pulse.
REQ-026 meas_en=0 in HOLD SHALL NOT drop the held result; the result waits for result_ready.
REQ-027 A rise and a fall pulse in the same cycle are impossible after synchronization; no special handling is required.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE.
REQ-029 While rst=1, the synchronizer and edge registers SHALL be 0.
REQ-030 While rst=1, result_valid, period, high_time, overflow and timeout SHALL be 0.
REQ-031 rst asserted mid-measurement SHALL abort the measurement with no result emitted.
REQ-032 After rst deasserts, the first result SHALL require two fresh rising edges.

Configuration
REQ-033 Macro FREQ_METER_TIMEOUT_EN defined: an idle counter SHALL run in ARM and MEASURE and clear on any rise or fall pulse.
REQ-034 When the idle counter reaches TIMEOUT, the block SHALL go to HOLD with timeout=1, period=0 and high_time=0 (a stuck or absent input).
REQ-035 timeout SHALL clear on HOLD exit.
REQ-036 Macro not defined: no idle counter and no timeout port; ARM and MEASURE wait indefinitely.

Structure
REQ-037 Package freq_meter_pkg SHALL hold the FSM state enum typedef (IDLE, ARM, MEASURE, HOLD) and the default CNT_W and TIMEOUT constants.
REQ-038 Sub-module edge_sync SHALL contain the 2-flop synchronizer and the edge detector, with outputs rise and fall; freq_meter SHALL instantiate it once.

Verification
REQ-039 sig_in from a divider with N=5 (10-cycle period, 50% duty), meas_en=1, result_ready=1 -> period=10, high_time=5, overflow=0.
REQ-040 sig_in high 3 cycles and low 9 cycles, result_ready held low 50 cycles -> result_valid stays 1 with period=12 and high_time=3 stable; it clears 1 cycle after result_ready rises.
REQ-041 CNT_W=4, sig_in period 40 -> period=15, overflow=1.
REQ-042 meas_en dropped 4 cycles into MEASURE -> no result_valid; re-enabling meas_en requires a fresh edge pair.
REQ-043 rst pulsed mid-MEASURE -> all outputs 0 next cycle; the next result after reset is correct.
REQ-044 With FREQ_METER_TIMEOUT_EN, TIMEOUT=100 and sig_in held at 0 -> result_valid=1 and timeout=1 at 100 cycles after ARM, with period=0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency / duty meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    HOLD
  } state_t;

  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 1048576;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer plus registered edge detector for sig_in.
// Rise/fall pulses are one cycle wide, three clocks after the input edge.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of sig_in in clk cycles.
// Define FREQ_METER_TIMEOUT_EN to add the idle-timeout and timeout port.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow
`ifdef FREQ_METER_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           state;
  logic             rise, fall;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic             hi_done, ovf;

  edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign result_valid = (state == HOLD);

`ifdef FREQ_METER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle;
  logic          counting, to_hit;

  assign counting = (state == ARM || state == MEASURE) && meas_en;
  assign to_hit   = counting && !rise && !fall &&
                    (idle == IW'(TIMEOUT - 1));

  // Any edge proves the input is alive.
  always_ff @(posedge clk) begin
    if (rst)
      idle <= '0;
    else if (!counting || rise || fall)
      idle <= '0;
    else
      idle <= idle + IW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      hi_done   <= 1'b0;
      ovf       <= 1'b0;
      period    <= '0;
      high_time <= '0;
      overflow  <= 1'b0;
`ifdef FREQ_METER_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (meas_en) state <= ARM;
        ARM: begin
          if (!meas_en) begin
            state <= IDLE;
          end else if (rise) begin
            per_cnt <= ONE;
            hi_cnt  <= ONE;
            hi_done <= 1'b0;
            ovf     <= 1'b0;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (!meas_en) begin
            state <= IDLE;
          end else if (rise) begin
            period    <= per_cnt;
            high_time <= hi_cnt;
            overflow  <= ovf;
            state     <= HOLD;
          end else begin
            if (per_cnt == MAX) ovf <= 1'b1;
            else per_cnt <= per_cnt + ONE;
            // High count stops at the first falling edge.
            if (fall) begin
              hi_done <= 1'b1;
            end else if (!hi_done) begin
              if (hi_cnt == MAX) ovf <= 1'b1;
              else hi_cnt <= hi_cnt + ONE;
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            state <= meas_en ? ARM : IDLE;
`ifdef FREQ_METER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef FREQ_METER_TIMEOUT_EN
      if (to_hit) begin
        state     <= HOLD;
        period    <= '0;
        high_time <= '0;
        overflow  <= 1'b0;
        timeout   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 32-bit and a 4-bit instance
// share one stimulus; expected values are hand-computed.
module tb_freq_meter;

  logic        clk;
  logic        rst;
  logic        sig_in;
  logic        meas_en;
  logic        result_ready;
  logic        valid;
  logic [31:0] per;
  logic [31:0] hi_t;
  logic        ovf;
  logic        v4;
  logic [3:0]  p4;
  logic [3:0]  h4;
  logic        o4;
`ifdef FREQ_METER_TIMEOUT_EN
  logic        tmo;
  logic        tmo4;
`endif

  logic gen_en, g, m;
  int   hi, lo;
  int   n_chk, n_fail;

  assign sig_in = gen_en ? g : m;

  freq_meter #(.CNT_W(32), .TIMEOUT(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .meas_en      (meas_en),
    .result_ready (result_ready),
    .result_valid (valid),
    .period       (per),
    .high_time    (hi_t),
    .overflow     (ovf)
`ifdef FREQ_METER_TIMEOUT_EN
    ,
    .timeout      (tmo)
`endif
  );

  freq_meter #(.CNT_W(4), .TIMEOUT(100)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .meas_en      (meas_en),
    .result_ready (result_ready),
    .result_valid (v4),
    .period       (p4),
    .high_time    (h4),
    .overflow     (o4)
`ifdef FREQ_METER_TIMEOUT_EN
    ,
    .timeout      (tmo4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n;
    n = 0;
    while (!valid && n < maxc) begin
      tick();
      n++;
    end
    check(tag, valid, 1);
  endtask

  // Quiesce the meter and the generator, then start a clean waveform.
  task automatic restart(input int h, input int l);
    meas_en      = 1'b0;
    gen_en       = 1'b0;
    result_ready = 1'b1;
    repeat (60) tick();
    hi      = h;
    lo      = l;
    gen_en  = 1'b1;
    meas_en = 1'b1;
  endtask

  int vcnt;
  task automatic drive(input logic val, input int n);
    m = val;
    repeat (n) begin
      tick();
      if (valid) vcnt++;
    end
  endtask

  initial begin
    g = 1'b0;
    forever begin
      if (gen_en) begin
        g = 1'b1;
        for (int i = 0; i < hi && gen_en; i++) tick();
        g = 1'b0;
        for (int i = 0; i < lo && gen_en; i++) tick();
      end else begin
        tick();
      end
    end
  end

  initial begin
    int bad;
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    gen_en       = 1'b0;
    m            = 1'b0;
    hi           = 5;
    lo           = 5;
    meas_en      = 1'b0;
    result_ready = 1'b0;
    repeat (4) tick();
    check("rst_valid", valid, 0);
    check("rst_period", per, 0);
    check("rst_high", hi_t, 0);
    check("rst_ovf", ovf, 0);
    check("rst_valid4", v4, 0);
    rst = 1'b0;

    // 10-cycle period, 50% duty
    restart(5, 5);
    wait_valid("div5_valid", 100);
    check("div5_period", per, 10);
    check("div5_high", hi_t, 5);
    check("div5_ovf", ovf, 0);
    check("div5_period4", p4, 10);
    check("div5_high4", h4, 5);
    tick();
    check("div5_drop", valid, 0);

    // held result with back-pressure
    restart(3, 9);
    result_ready = 1'b0;
    wait_valid("hold_valid", 100);
    check("hold_period", per, 12);
    check("hold_high", hi_t, 3);
    bad = 0;
    repeat (50) begin
      tick();
      if (!(valid && per == 12 && hi_t == 3)) bad++;
    end
    check("hold_stable", bad, 0);
    result_ready = 1'b1;
    check("hold_still", valid, 1);
    tick();
    check("hold_release", valid, 0);

    // saturation on the 4-bit instance
    restart(20, 20);
    wait_valid("sat_valid", 200);
    check("sat_period4", p4, 15);
    check("sat_high4", h4, 15);
    check("sat_ovf4", o4, 1);
    check("sat_valid4", v4, 1);
    check("sat_period", per, 40);
    check("sat_high", hi_t, 20);
    check("sat_ovf", ovf, 0);

    // exactly full scale, no overflow
    restart(7, 8);
    wait_valid("edge_valid", 100);
    check("edge_period4", p4, 15);
    check("edge_high4", h4, 7);
    check("edge_ovf4", o4, 0);

    // abort by meas_en, then fresh edge pair
    meas_en = 1'b0;
    gen_en  = 1'b0;
    m       = 1'b0;
    repeat (60) tick();
    vcnt    = 0;
    meas_en = 1'b1;
    drive(1'b0, 5);
    drive(1'b1, 8);
    meas_en = 1'b0;
    drive(1'b1, 2);
    drive(1'b0, 5);
    drive(1'b1, 5);
    meas_en = 1'b1;
    drive(1'b1, 6);
    drive(1'b0, 6);
    drive(1'b1, 4);
    drive(1'b0, 6);
    m = 1'b1;
    check("abort_no_valid", vcnt, 0);
    wait_valid("abort_valid", 10);
    check("abort_period", per, 10);
    check("abort_high", hi_t, 4);

    // reset mid-measurement
    m = 1'b0;
    restart(6, 4);
    wait_valid("rst_mid_first", 100);
    repeat (13) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_valid", valid, 0);
    check("rst_mid_period", per, 0);
    check("rst_mid_high", hi_t, 0);
    check("rst_mid_ovf", ovf, 0);
    rst = 1'b0;
    wait_valid("rst_after_valid", 100);
    check("rst_after_period", per, 10);
    check("rst_after_high", hi_t, 6);

`ifdef FREQ_METER_TIMEOUT_EN
    // stuck-low input
    meas_en      = 1'b0;
    gen_en       = 1'b0;
    m            = 1'b0;
    result_ready = 1'b1;
    repeat (60) tick();
    result_ready = 1'b0;
    meas_en      = 1'b1;
    repeat (100) tick();
    check("to_early", valid, 0);
    tick();
    check("to_valid", valid, 1);
    check("to_flag", tmo, 1);
    check("to_period", per, 0);
    check("to_high", hi_t, 0);
    result_ready = 1'b1;
    tick();
    check("to_clear", tmo, 0);
    check("to_drop", valid, 0);
    meas_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
